// File: rtl/interrupt_detector_pkg.sv
// Shared ECO32 CPU constants for the interrupt path.
package interrupt_detector_pkg;

  // Number of external interrupt request lines and the width of a line number.
  localparam int IRQ_LINE_COUNT  = 16;
  localparam int IRQ_INDEX_WIDTH = 4;

  // Symbolic PSW field positions: per-line mask in the low half, current global enable above it.
  localparam int PSW_MASK_LSB = 0;
  localparam int PSW_MASK_MSB = PSW_MASK_LSB + IRQ_LINE_COUNT - 1;
  localparam int PSW_IEN_BIT  = 23;

  typedef logic [IRQ_LINE_COUNT-1:0]  irq_vec_t;
  typedef logic [IRQ_INDEX_WIDTH-1:0] irq_idx_t;

endpackage

// File: rtl/interrupt_detector_if.sv
// Request/result bundle between the interrupt sources/PSW and the detector.
interface interrupt_detector_if;
  import interrupt_detector_pkg::*;

  irq_vec_t externalInterruptLines;
  irq_vec_t pswInterruptMask;
  logic     pswInterruptEnable;
  logic     interruptActive;
  irq_idx_t index;

  modport master (
    output externalInterruptLines,
    output pswInterruptMask,
    output pswInterruptEnable,
    input  interruptActive,
    input  index
  );

  modport slave (
    input  externalInterruptLines,
    input  pswInterruptMask,
    input  pswInterruptEnable,
    output interruptActive,
    output index
  );

endinterface

// File: rtl/interrupt_detector_priority_encoder.sv
// Combinational lowest-set-bit encoder: bit 0 has the highest priority.
module interrupt_priority_encoder #(
  parameter int LINE_COUNT  = 16,
  parameter int INDEX_WIDTH = 4
) (
  input  logic [LINE_COUNT-1:0]  vec,
  output logic                   valid,
  output logic [INDEX_WIDTH-1:0] index
);

  // Scan from the top down so the lowest set bit is the last one written; empty vector yields 0.
  always_comb begin
    valid = |vec;
    index = '0;
    for (int i = LINE_COUNT - 1; i >= 0; i--) begin
      if (vec[i]) begin
        index = INDEX_WIDTH'(i);
      end
    end
  end

endmodule

// File: rtl/interrupt_detector.sv
// Registered interrupt detector: gates requests by PSW mask and global enable,
// picks the lowest pending line and registers the result one clock later.
module interrupt_detector
  import interrupt_detector_pkg::*;
#(
  // LINE_COUNT must equal 2**INDEX_WIDTH; the interface is sized from the package.
  parameter int LINE_COUNT  = IRQ_LINE_COUNT,
  parameter int INDEX_WIDTH = IRQ_INDEX_WIDTH
) (
  input  logic                 clock,
  input  logic                 reset,
  interrupt_detector_if.slave  irq
);

  logic [LINE_COUNT-1:0]  pending;
  logic                   enc_valid;
  logic [INDEX_WIDTH-1:0] enc_index;

  logic                   active_d, active_q;
  logic [INDEX_WIDTH-1:0] index_d,  index_q;

  // Pending lines: requested and allowed by the mask, all suppressed when globally disabled.
  always_comb begin
    pending = '0;
    if (irq.pswInterruptEnable) begin
      pending = irq.externalInterruptLines & irq.pswInterruptMask;
    end
  end

  interrupt_priority_encoder #(
    .LINE_COUNT  (LINE_COUNT),
    .INDEX_WIDTH (INDEX_WIDTH)
  ) u_encoder (
    .vec   (pending),
    .valid (enc_valid),
    .index (enc_index)
  );

  // Next state is simply the encoder result; no hold or enable condition.
  always_comb begin
    active_d = enc_valid;
    index_d  = enc_index;
  end

  // Output registers; reset clears them immediately regardless of the clock.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      active_q <= 1'b0;
      index_q  <= '0;
    end else begin
      active_q <= active_d;
      index_q  <= index_d;
    end
  end

  assign irq.interruptActive = active_q;
  assign irq.index           = index_q;

endmodule

// File: tb/tb_interrupt_detector.sv
// Directed self-checking bench for interrupt_detector.
module tb_interrupt_detector;
  import interrupt_detector_pkg::*;

  logic clock;
  logic reset;
  int   n_checks;
  int   n_fail;

  interrupt_detector_if u_if ();

  interrupt_detector dut (
    .clock (clock),
    .reset (reset),
    .irq   (u_if.slave)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Advance to just after the next rising edge; inputs changed here settle well before the following edge.
  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic drive(input irq_vec_t lines, input irq_vec_t mask, input logic en);
    u_if.externalInterruptLines = lines;
    u_if.pswInterruptMask       = mask;
    u_if.pswInterruptEnable     = en;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    drive(16'h0020, 16'hFFFF, 1'b1);
    step();
    n_checks++;
    if (u_if.interruptActive !== 1'b1 || u_if.index !== 4'd5) begin
      n_fail++;
      $display("FAIL pre_reset: active=%b index=%0d, expected active=1 index=5", u_if.interruptActive, u_if.index);
    end
    // Assert reset mid-cycle, away from any edge.
    #2 reset = 1'b1;
    #1;
    n_checks++;
    if (u_if.interruptActive !== 1'b0 || u_if.index !== 4'd0) begin
      n_fail++;
      $display("FAIL reset_async: active=%b index=%0d, expected active=0 index=0", u_if.interruptActive, u_if.index);
    end
    step();
    n_checks++;
    if (u_if.interruptActive !== 1'b0 || u_if.index !== 4'd0) begin
      n_fail++;
      $display("FAIL reset_held: active=%b index=%0d, expected active=0 index=0", u_if.interruptActive, u_if.index);
    end
    reset = 1'b0;
    step();
    n_checks++;
    if (u_if.interruptActive !== 1'b1 || u_if.index !== 4'd5) begin
      n_fail++;
      $display("FAIL reset_release: active=%b index=%0d, expected active=1 index=5", u_if.interruptActive, u_if.index);
    end
  endtask

  task automatic test_single_line();
    drive(16'h0000, 16'hFFFF, 1'b1);
    step();
    n_checks++;
    if (u_if.interruptActive !== 1'b0 || u_if.index !== 4'd0) begin
      n_fail++;
      $display("FAIL idle: active=%b index=%0d, expected active=0 index=0", u_if.interruptActive, u_if.index);
    end
    drive(16'h0020, 16'hFFFF, 1'b1);
    #3;
    n_checks++;
    if (u_if.interruptActive !== 1'b0) begin
      n_fail++;
      $display("FAIL single_before_edge: active=%b, expected active=0", u_if.interruptActive);
    end
    step();
    n_checks++;
    if (u_if.interruptActive !== 1'b1 || u_if.index !== 4'd5) begin
      n_fail++;
      $display("FAIL single_line5: active=%b index=%0d, expected active=1 index=5", u_if.interruptActive, u_if.index);
    end
  endtask

  task automatic test_priority();
    drive(16'h0120, 16'hFFFF, 1'b1);
    step();
    n_checks++;
    if (u_if.interruptActive !== 1'b1 || u_if.index !== 4'd5) begin
      n_fail++;
      $display("FAIL prio_add8: active=%b index=%0d, expected active=1 index=5", u_if.interruptActive, u_if.index);
    end
    drive(16'h0100, 16'hFFFF, 1'b1);
    #3;
    n_checks++;
    if (u_if.interruptActive !== 1'b1 || u_if.index !== 4'd5) begin
      n_fail++;
      $display("FAIL prio_hold_before_edge: active=%b index=%0d, expected active=1 index=5", u_if.interruptActive, u_if.index);
    end
    step();
    n_checks++;
    if (u_if.interruptActive !== 1'b1 || u_if.index !== 4'd8) begin
      n_fail++;
      $display("FAIL prio_handover: active=%b index=%0d, expected active=1 index=8", u_if.interruptActive, u_if.index);
    end
    drive(16'h0000, 16'hFFFF, 1'b1);
    step();
    n_checks++;
    if (u_if.interruptActive !== 1'b0 || u_if.index !== 4'd0) begin
      n_fail++;
      $display("FAIL prio_drop_all: active=%b index=%0d, expected active=0 index=0", u_if.interruptActive, u_if.index);
    end
  endtask

  task automatic test_global_enable();
    drive(16'h0120, 16'hFFFF, 1'b0);
    for (int i = 0; i < 3; i++) begin
      step();
      n_checks++;
      if (u_if.interruptActive !== 1'b0 || u_if.index !== 4'd0) begin
        n_fail++;
        $display("FAIL enable_off_cycle%0d: active=%b index=%0d, expected active=0 index=0", i, u_if.interruptActive, u_if.index);
      end
    end
    drive(16'h0120, 16'hFFFF, 1'b1);
    step();
    n_checks++;
    if (u_if.interruptActive !== 1'b1 || u_if.index !== 4'd5) begin
      n_fail++;
      $display("FAIL enable_on: active=%b index=%0d, expected active=1 index=5", u_if.interruptActive, u_if.index);
    end
    drive(16'h0120, 16'hFFFF, 1'b0);
    step();
    n_checks++;
    if (u_if.interruptActive !== 1'b0 || u_if.index !== 4'd0) begin
      n_fail++;
      $display("FAIL enable_clear: active=%b index=%0d, expected active=0 index=0", u_if.interruptActive, u_if.index);
    end
  endtask

  task automatic test_mask();
    drive(16'h0120, 16'hFFDF, 1'b1);
    step();
    n_checks++;
    if (u_if.interruptActive !== 1'b1 || u_if.index !== 4'd8) begin
      n_fail++;
      $display("FAIL mask_FFDF: active=%b index=%0d, expected active=1 index=8", u_if.interruptActive, u_if.index);
    end
    drive(16'h0120, 16'hFEDF, 1'b1);
    step();
    n_checks++;
    if (u_if.interruptActive !== 1'b0 || u_if.index !== 4'd0) begin
      n_fail++;
      $display("FAIL mask_FEDF: active=%b index=%0d, expected active=0 index=0", u_if.interruptActive, u_if.index);
    end
    drive(16'h0120, 16'hFEFF, 1'b1);
    step();
    n_checks++;
    if (u_if.interruptActive !== 1'b1 || u_if.index !== 4'd5) begin
      n_fail++;
      $display("FAIL mask_FEFF: active=%b index=%0d, expected active=1 index=5", u_if.interruptActive, u_if.index);
    end
  endtask

  task automatic test_simultaneous();
    // Lines 3 and 12 appear, line 3 masked, enable toggled on in the same cycle from a disabled state.
    drive(16'h0120, 16'hFFFF, 1'b0);
    step();
    drive(16'h1008, 16'hFFF7, 1'b1);
    step();
    n_checks++;
    if (u_if.interruptActive !== 1'b1 || u_if.index !== 4'd12) begin
      n_fail++;
      $display("FAIL simultaneous: active=%b index=%0d, expected active=1 index=12", u_if.interruptActive, u_if.index);
    end
  endtask

  task automatic test_extremes();
    drive(16'h0001, 16'hFFFF, 1'b1);
    step();
    n_checks++;
    if (u_if.interruptActive !== 1'b1 || u_if.index !== 4'd0) begin
      n_fail++;
      $display("FAIL line0: active=%b index=%0d, expected active=1 index=0", u_if.interruptActive, u_if.index);
    end
    drive(16'h8000, 16'hFFFF, 1'b1);
    step();
    n_checks++;
    if (u_if.interruptActive !== 1'b1 || u_if.index !== 4'd15) begin
      n_fail++;
      $display("FAIL line15: active=%b index=%0d, expected active=1 index=15", u_if.interruptActive, u_if.index);
    end
    drive(16'hFFFF, 16'hFFFF, 1'b1);
    step();
    n_checks++;
    if (u_if.interruptActive !== 1'b1 || u_if.index !== 4'd0) begin
      n_fail++;
      $display("FAIL all_lines: active=%b index=%0d, expected active=1 index=0", u_if.interruptActive, u_if.index);
    end
    drive(16'hFFFF, 16'h7FFE, 1'b1);
    step();
    n_checks++;
    if (u_if.interruptActive !== 1'b1 || u_if.index !== 4'd1) begin
      n_fail++;
      $display("FAIL all_lines_ends_masked: active=%b index=%0d, expected active=1 index=1", u_if.interruptActive, u_if.index);
    end
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    reset    = 1'b1;
    drive(16'h0000, 16'h0000, 1'b0);
    #1;
    n_checks++;
    if (u_if.interruptActive !== 1'b0 || u_if.index !== 4'd0) begin
      n_fail++;
      $display("FAIL initial_reset: active=%b index=%0d, expected active=0 index=0", u_if.interruptActive, u_if.index);
    end
    step();
    test_reset();
    test_single_line();
    test_priority();
    test_global_enable();
    test_mask();
    test_simultaneous();
    test_extremes();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
